hdmi_timing_decoder: RTL

Downstream stage of the HDMI/VGA pixel source. Consumes the raw DE/HS/VS/RGB stream and re-emits it registered, with pixel coordinates and frame/line markers attached. It also measures active width and height per frame and reports lock once timing is stable. It feeds the colour-conversion and skin-segmentation stages, which rely on its coordinates and its start-of-frame (SOF) pulse.

---
 rtl/hdmi_timing_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hdmi_timing_decoder.sv
// Registers the incoming DE/HS/VS/RGB stream and tags it with pixel coordinates and SOF/SOL markers.
// It also measures the active width and height of each frame and reports lock once they are stable.
module hdmi_timing_decoder #(
    parameter int unsigned XW          = 11,
    parameter int unsigned YW          = 11,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic          hdmi_clk,
    input  logic          rst_n,
    input  logic          in_de,
    input  logic          in_hs,
    input  logic          in_vs,
    input  logic [7:0]    in_r,
    input  logic [7:0]    in_g,
    input  logic [7:0]    in_b,
    output logic          out_de,
    output logic          out_hs,
    output logic          out_vs,
    output logic [7:0]    out_r,
    output logic [7:0]    out_g,
    output logic [7:0]    out_b,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_sof,
    output logic          out_sol,
    output logic          frame_valid,
    output logic [XW-1:0] meas_w,
    output logic [YW-1:0] meas_h,
    output logic          locked,
    output logic          line_err
);

    localparam int unsigned MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_FRAMES);
    localparam logic [XW-1:0] X_MAX = '1;
    localparam logic [YW-1:0] Y_MAX = '1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] first_w;
    logic          err_sh;
    logic          sof_pending;
    logic [MW-1:0] match_cnt;

    logic          vs_edge, de_fall, de_rise, first_line, err_eff, close_out, cand_match;
    logic [XW-1:0] x_inc, first_w_eff;
    logic [YW-1:0] y_line;
    logic [MW-1:0] match_nxt;

    // out_de/out_vs double as the previous-cycle DE/VS for edge detection
    always_comb begin
        vs_edge     = (in_vs == VS_POL) && (out_vs != VS_POL);
        de_fall     = out_de && !in_de;
        de_rise     = in_de && !out_de;
        x_inc       = (x == X_MAX) ? x : x + 1'b1;
        y_line      = (de_fall && y != Y_MAX) ? y + 1'b1 : y;
        first_line  = de_fall && (y == '0);
        first_w_eff = first_line ? x : first_w;
        err_eff     = err_sh || (de_fall && (y != '0) && (x != first_w));
        close_out   = vs_edge && frame_valid && (y_line != '0);
        cand_match  = (first_w_eff == meas_w) && (y_line == meas_h) && !err_eff;
        if (!cand_match) begin
            match_nxt = '0;
        end else if (match_cnt >= LOCK_MAX) begin
            match_nxt = LOCK_MAX;
        end else begin
            match_nxt = match_cnt + 1'b1;
        end
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_de      <= 1'b0;
            out_hs      <= ~HS_POL;
            out_vs      <= ~VS_POL;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_sof     <= 1'b0;
            out_sol     <= 1'b0;
            frame_valid <= 1'b0;
            meas_w      <= '0;
            meas_h      <= '0;
            locked      <= 1'b0;
            line_err    <= 1'b0;
            x           <= '0;
            y           <= '0;
            first_w     <= '0;
            err_sh      <= 1'b0;
            sof_pending <= 1'b0;
            match_cnt   <= '0;
        end else begin
            out_de  <= in_de;
            out_hs  <= in_hs;
            out_vs  <= in_vs;
            out_r   <= in_r;
            out_g   <= in_g;
            out_b   <= in_b;
            out_sol <= de_rise;
            out_sof <= in_de && sof_pending && frame_valid;

            if (in_de) begin
                out_x <= x;
                out_y <= y;
                x     <= x_inc;
            end else if (de_fall) begin
                x <= '0;
            end

            if (first_line) begin
                first_w <= x;
            end

            if (vs_edge) begin
                sof_pending <= 1'b1;
            end else if (in_de && frame_valid) begin
                sof_pending <= 1'b0;
            end

            // The line just ended is folded into y and err_eff before the frame is closed
            y      <= vs_edge ? '0 : y_line;
            err_sh <= vs_edge ? 1'b0 : err_eff;
            if (vs_edge) begin
                frame_valid <= 1'b1;
            end

            if (close_out) begin
                meas_w    <= first_w_eff;
                meas_h    <= y_line;
                match_cnt <= match_nxt;
                locked    <= (match_nxt >= LOCK_MAX);
                line_err  <= err_eff;
            end
        end
    end

endmodule
